// File: rtl/sdram_scheduler_pkg.sv
// Shared types and timing constants for the SDRAM scheduler.
// Owner and FSM encodings are common to the RTL and its bench.
package sdram_scheduler_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    // Refresh cadence derived from the logic clock: one credit every 5 us.
    localparam int FREQ_MHZ             = 32;
    localparam int REFRESH_PERIOD_NS    = 5000;
    localparam int DEF_REFRESH_INTERVAL = FREQ_MHZ * REFRESH_PERIOD_NS / 1000;

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_PPU,
        OWN_LDR,
        OWN_REF
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/sdram_scheduler_if.sv
// Requester ports and controller command bus of the SDRAM scheduler.
// slave is the scheduler view; master is the requesters plus controller.
interface sdram_scheduler_if;
    import sdram_scheduler_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_ack;
    logic              ppu_done;
    logic [DATA_W-1:0] ppu_rdata;

    logic              ldr_active;
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic              ldr_done;

    logic              mc_read_a;
    logic              mc_read_b;
    logic              mc_write;
    logic              mc_refresh;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_din;
    logic              mc_busy;
    logic [DATA_W-1:0] mc_dout_a;
    logic [DATA_W-1:0] mc_dout_b;

    logic              err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_done, cpu_rdata,
        input  ppu_req, ppu_addr,
        output ppu_ack, ppu_done, ppu_rdata,
        input  ldr_active, ldr_req, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_done,
        output mc_read_a, mc_read_b, mc_write, mc_refresh,
        output mc_addr, mc_din,
        input  mc_busy, mc_dout_a, mc_dout_b,
        output err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_done, cpu_rdata,
        output ppu_req, ppu_addr,
        input  ppu_ack, ppu_done, ppu_rdata,
        output ldr_active, ldr_req, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_done,
        input  mc_read_a, mc_read_b, mc_write, mc_refresh,
        input  mc_addr, mc_din,
        output mc_busy, mc_dout_a, mc_dout_b,
        input  err
    );

endinterface

// File: rtl/sdram_scheduler_refresh_credit.sv
// Refresh interval timer and 3-bit saturating credit counter.
// A wrap and an issue in the same cycle cancel out.
module sdram_scheduler_refresh_credit #(
    parameter int INTERVAL    = 160,
    parameter int MAX_PENDING = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic issue,
    output logic has_credit,
    output logic urgent
);
    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    logic [IW-1:0] ival_q, ival_d;
    logic [2:0]    credit_q, credit_d;
    logic          wrap;

    // Advance the interval timer and adjust credits on wrap/issue.
    always_comb begin
        wrap     = (ival_q == IW'(INTERVAL - 1));
        ival_d   = wrap ? '0 : ival_q + IW'(1);
        credit_d = credit_q;
        if (wrap && !issue) begin
            if (credit_q != 3'd7) credit_d = credit_q + 3'd1;
        end else if (issue && !wrap) begin
            if (credit_q != 3'd0) credit_d = credit_q - 3'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ival_q   <= '0;
            credit_q <= '0;
        end else begin
            ival_q   <= ival_d;
            credit_q <= credit_d;
        end
    end

    assign has_credit = (credit_q != 3'd0);
    assign urgent     = (32'(credit_q) >= MAX_PENDING);

endmodule

// File: rtl/sdram_scheduler.sv
// Arbiter/sequencer sharing one SDRAM controller command slot.
// All outputs are registered; one operation is in flight at a time.
module sdram_scheduler
    import sdram_scheduler_pkg::*;
#(
    parameter int REFRESH_INTERVAL    = DEF_REFRESH_INTERVAL,
    parameter int REFRESH_MAX_PENDING = 4,
    parameter int BUSY_TIMEOUT        = 2
) (
    input  logic             clk,
    input  logic             resetn,
    sdram_scheduler_if.slave bus
);
    localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    state_t            state_q, state_d;
    owner_t            own_q, own_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ppu_ack_q, ppu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              cpu_done_q, cpu_done_d;
    logic              ppu_done_q, ppu_done_d;
    logic              ldr_done_q, ldr_done_d;
    logic              rd_a_q, rd_a_d;
    logic              rd_b_q, rd_b_d;
    logic              wr_q, wr_d;
    logic              rf_q, rf_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
    logic              err_q, err_d;

    logic   grant;
    owner_t win;
    logic   has_credit;
    logic   urgent;
    logic   ref_issue;
    logic   fin;

    sdram_scheduler_refresh_credit #(
        .INTERVAL   (REFRESH_INTERVAL),
        .MAX_PENDING(REFRESH_MAX_PENDING)
    ) u_credit (
        .clk       (clk),
        .resetn    (resetn),
        .issue     (ref_issue),
        .has_credit(has_credit),
        .urgent    (urgent)
    );

    // Pick the highest-priority eligible requester while idle.
    always_comb begin
        grant = 1'b0;
        win   = OWN_CPU;
        if (state_q == ST_IDLE && !bus.mc_busy) begin
            priority case (1'b1)
                urgent: begin
                    grant = 1'b1;
                    win   = OWN_REF;
                end
                bus.ldr_req: begin
                    grant = 1'b1;
                    win   = OWN_LDR;
                end
                (bus.ppu_req && !bus.ldr_active): begin
                    grant = 1'b1;
                    win   = OWN_PPU;
                end
                (bus.cpu_req && !bus.ldr_active): begin
                    grant = 1'b1;
                    win   = OWN_CPU;
                end
                has_credit: begin
                    grant = 1'b1;
                    win   = OWN_REF;
                end
                default: ;
            endcase
        end
    end

    assign ref_issue = grant && (win == OWN_REF);

    // Next state, command/ack pulses and completion handling.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        tmo_d       = tmo_q;
        cpu_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_done_d  = 1'b0;
        ppu_done_d  = 1'b0;
        ldr_done_d  = 1'b0;
        rd_a_d      = 1'b0;
        rd_b_d      = 1'b0;
        wr_d        = 1'b0;
        rf_d        = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;
        err_d       = err_q;
        fin         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                    own_d   = win;
                    unique case (win)
                        OWN_CPU: begin
                            we_d      = bus.cpu_we;
                            addr_d    = bus.cpu_addr;
                            din_d     = bus.cpu_wdata;
                            cpu_ack_d = 1'b1;
                            wr_d      = bus.cpu_we;
                            rd_a_d    = !bus.cpu_we;
                        end
                        OWN_PPU: begin
                            we_d      = 1'b0;
                            addr_d    = bus.ppu_addr;
                            din_d     = '0;
                            ppu_ack_d = 1'b1;
                            rd_b_d    = 1'b1;
                        end
                        OWN_LDR: begin
                            we_d      = 1'b1;
                            addr_d    = bus.ldr_addr;
                            din_d     = bus.ldr_wdata;
                            ldr_ack_d = 1'b1;
                            wr_d      = 1'b1;
                        end
                        OWN_REF: begin
                            we_d   = 1'b0;
                            addr_d = '0;
                            din_d  = '0;
                            rf_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                tmo_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (bus.mc_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    fin     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.mc_busy) begin
                    fin     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            unique case (own_q)
                OWN_CPU: begin
                    cpu_done_d = 1'b1;
                    if (!we_q) cpu_rdata_d = bus.mc_dout_a;
                end
                OWN_PPU: begin
                    ppu_done_d  = 1'b1;
                    ppu_rdata_d = bus.mc_dout_b;
                end
                OWN_LDR: ldr_done_d = 1'b1;
                OWN_REF: ;
            endcase
        end
    end

    // State and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            own_q       <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            tmo_q       <= '0;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ppu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            rd_a_q      <= 1'b0;
            rd_b_q      <= 1'b0;
            wr_q        <= 1'b0;
            rf_q        <= 1'b0;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            tmo_q       <= tmo_d;
            cpu_ack_q   <= cpu_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_done_q  <= cpu_done_d;
            ppu_done_q  <= ppu_done_d;
            ldr_done_q  <= ldr_done_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            wr_q        <= wr_d;
            rf_q        <= rf_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_done   = cpu_done_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ppu_ack    = ppu_ack_q;
    assign bus.ppu_done   = ppu_done_q;
    assign bus.ppu_rdata  = ppu_rdata_q;
    assign bus.ldr_ack    = ldr_ack_q;
    assign bus.ldr_done   = ldr_done_q;
    assign bus.mc_read_a  = rd_a_q;
    assign bus.mc_read_b  = rd_b_q;
    assign bus.mc_write   = wr_q;
    assign bus.mc_refresh = rf_q;
    assign bus.mc_addr    = addr_q;
    assign bus.mc_din     = din_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Scoreboard bench for sdram_scheduler with a simple controller model.
// Expected done events are queued at issue and popped by a monitor.
module tb_sdram_scheduler;
    import sdram_scheduler_pkg::*;

    typedef struct {
        owner_t     port;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    sdram_scheduler_if bus();

    sdram_scheduler #(
        .REFRESH_INTERVAL   (16),
        .REFRESH_MAX_PENDING(4),
        .BUSY_TIMEOUT       (2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr = 0;
    int         n_ref = 0;
    int         n_ref_cpu = 0;
    int         n_cpu_ack_ldr = 0;
    int         n_done = 0;
    bit         no_busy = 1'b0;
    logic [7:0] mem [logic [21:0]];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [21:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return mem.exists(a) ? mem[a] : (lo ^ 8'hA5);
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.cpu_ack, bus.cpu_done, bus.cpu_rdata,
                    bus.ppu_ack, bus.ppu_done, bus.ppu_rdata,
                    bus.ldr_ack, bus.ldr_done,
                    bus.mc_read_a, bus.mc_read_b, bus.mc_write,
                    bus.mc_refresh, bus.mc_addr, bus.mc_din, bus.err});
    endfunction

    // Controller model: busy one cycle after a command, for 3 cycles.
    initial begin : model
        logic [21:0] a;
        logic [7:0]  d;
        logic        ra, rb, w;
        forever begin
            @(posedge clk);
            if (resetn && (bus.mc_read_a || bus.mc_read_b ||
                           bus.mc_write || bus.mc_refresh) && !no_busy) begin
                a  = bus.mc_addr;
                d  = bus.mc_din;
                ra = bus.mc_read_a;
                rb = bus.mc_read_b;
                w  = bus.mc_write;
                #1 bus.mc_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                if (w) mem[a] = d;
                if (ra) begin
                    bus.mc_dout_a = rd_mem(a);
                    bus.mc_dout_b = ~rd_mem(a);
                end
                if (rb) begin
                    bus.mc_dout_b = rd_mem(a);
                    bus.mc_dout_a = ~rd_mem(a);
                end
                bus.mc_busy = 1'b0;
            end
        end
    end

    // Monitor: command exclusivity, counters and done scoreboard.
    always @(negedge clk) begin : mon
        exp_t       e;
        owner_t     p;
        logic [7:0] d;
        logic [3:0] cmd;
        if (resetn) begin
            cmd = {bus.mc_read_a, bus.mc_read_b, bus.mc_write, bus.mc_refresh};
            if (cmd != 4'd0) check("cmd_onehot", 64'($onehot(cmd)), 64'd1);
            if (bus.mc_write) n_wr++;
            if (bus.mc_refresh) begin
                n_ref++;
                if (bus.cpu_req) n_ref_cpu++;
            end
            if (bus.cpu_ack && bus.ldr_active) n_cpu_ack_ldr++;
            if (bus.cpu_done || bus.ppu_done || bus.ldr_done) begin
                n_done++;
                d = 8'h00;
                if (bus.cpu_done) begin
                    p = OWN_CPU;
                    d = bus.cpu_rdata;
                end else if (bus.ppu_done) begin
                    p = OWN_PPU;
                    d = bus.ppu_rdata;
                end else begin
                    p = OWN_LDR;
                end
                check("done_onehot",
                      64'($onehot({bus.cpu_done, bus.ppu_done, bus.ldr_done})),
                      64'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stray_done: got port %0d want none", p);
                end else begin
                    e = exp_q.pop_front();
                    check("done_port", 64'(p), 64'(e.port));
                    if (e.chk) check("done_data", 64'(d), 64'(e.data));
                end
            end
        end
    end

    task automatic wait_ack(input owner_t p, output int cyc);
        logic hit;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            hit = (p == OWN_CPU && bus.cpu_ack) ||
                  (p == OWN_PPU && bus.ppu_ack) ||
                  (p == OWN_LDR && bus.ldr_ack);
            if (hit) return;
            if (cyc >= 1000) begin
                n_vec++;
                n_err++;
                $display("FAIL ack_timeout: port %0d got no ack want ack", p);
                return;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d dones outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_op(input logic we, input logic [21:0] a,
                          input logic [7:0] wd, input logic [7:0] want);
        int c;
        exp_q.push_back('{OWN_CPU, !we, want});
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_req   = 1'b1;
        wait_ack(OWN_CPU, c);
        bus.cpu_req = 1'b0;
    endtask

    task automatic ppu_rd(input logic [21:0] a, input logic [7:0] want);
        int c;
        exp_q.push_back('{OWN_PPU, 1'b1, want});
        bus.ppu_addr = a;
        bus.ppu_req  = 1'b1;
        wait_ack(OWN_PPU, c);
        bus.ppu_req = 1'b0;
    endtask

    task automatic ldr_wr(input logic [21:0] a, input logic [7:0] wd);
        int c;
        exp_q.push_back('{OWN_LDR, 1'b0, 8'h00});
        bus.ldr_addr  = a;
        bus.ldr_wdata = wd;
        bus.ldr_req   = 1'b1;
        wait_ack(OWN_LDR, c);
        bus.ldr_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got hang want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int      c, c1, c2, n_acks, wr0, ref0, done0;
        longint  t_ppu, t_cpu;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.ppu_req    = 1'b0;
        bus.ppu_addr   = '0;
        bus.ldr_active = 1'b0;
        bus.ldr_req    = 1'b0;
        bus.ldr_addr   = '0;
        bus.ldr_wdata  = '0;
        bus.mc_busy    = 1'b1;
        bus.mc_dout_a  = '0;
        bus.mc_dout_b  = '0;
        mem[22'h000123] = 8'h5A;
        mem[22'h000456] = 8'h77;

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        resetn = 1'b1;

        // Controller initializing: request must wait.
        repeat (90) @(negedge clk);
        exp_q.push_back('{OWN_CPU, 1'b1, 8'h5A});
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 22'h000123;
        bus.cpu_req  = 1'b1;
        n_acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.cpu_ack) n_acks++;
        end
        check("ack_while_busy", 64'(n_acks), 64'd0);
        bus.mc_busy = 1'b0;
        wait_ack(OWN_CPU, c);
        check("rd_a_with_ack", 64'(bus.mc_read_a), 64'd1);
        check("rd_a_addr", 64'(bus.mc_addr), 64'h123);
        bus.cpu_req = 1'b0;
        drain();

        // Simultaneous CPU and PPU: PPU wins first.
        exp_q.push_back('{OWN_PPU, 1'b1, 8'h77});
        exp_q.push_back('{OWN_CPU, 1'b1, 8'h5A});
        bus.ppu_addr = 22'h000456;
        bus.cpu_addr = 22'h000123;
        bus.cpu_we   = 1'b0;
        bus.ppu_req  = 1'b1;
        bus.cpu_req  = 1'b1;
        t_ppu = 0;
        t_cpu = 0;
        fork
            begin
                wait_ack(OWN_PPU, c1);
                t_ppu = $time;
                check("rd_b_with_ack", 64'(bus.mc_read_b), 64'd1);
                bus.ppu_req = 1'b0;
            end
            begin
                wait_ack(OWN_CPU, c2);
                t_cpu = $time;
                bus.cpu_req = 1'b0;
            end
        join
        check("ppu_before_cpu", 64'(t_ppu < t_cpu), 64'd1);
        drain();
        cpu_op(1'b1, 22'h000777, 8'hC3, 8'h00);
        cpu_op(1'b0, 22'h000777, 8'h00, 8'hC3);
        drain();

        // Loader owns memory: CPU stays pending.
        wr0 = n_wr;
        n_cpu_ack_ldr = 0;
        bus.ldr_active = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 22'h001005;
        bus.cpu_req    = 1'b1;
        for (int i = 0; i < 16; i++) ldr_wr(22'h001000 + 22'(i), 8'(16 + 3 * i));
        drain();
        check("ldr_write_pulses", 64'(n_wr - wr0), 64'd16);
        check("cpu_ack_in_ldr", 64'(n_cpu_ack_ldr), 64'd0);
        exp_q.push_back('{OWN_CPU, 1'b1, 8'h1F});
        bus.ldr_active = 1'b0;
        wait_ack(OWN_CPU, c);
        bus.cpu_req = 1'b0;
        drain();

        // Continuous CPU traffic: urgent refresh must preempt.
        ref0 = n_ref_cpu;
        bus.cpu_we  = 1'b0;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back('{OWN_CPU, 1'b1, 8'(i) ^ 8'hA5});
            bus.cpu_addr = 22'h002000 + 22'(i);
            wait_ack(OWN_CPU, c);
        end
        bus.cpu_req = 1'b0;
        drain();
        check("refresh_preempts_cpu", 64'((n_ref_cpu - ref0) > 0), 64'd1);

        // Controller never goes busy: timeout sets err.
        exp_q.push_back('{OWN_CPU, 1'b0, 8'h00});
        bus.cpu_addr = 22'h000456;
        bus.cpu_req  = 1'b1;
        wait_ack(OWN_CPU, c);
        no_busy     = 1'b1;
        bus.cpu_req = 1'b0;
        check("err_before_timeout", 64'(bus.err), 64'd0);
        c = 0;
        while (!bus.err && c < 20) begin
            @(negedge clk);
            c++;
        end
        no_busy = 1'b0;
        check("err_latency", 64'(c), 64'd3);
        drain();
        ppu_rd(22'h000456, 8'h77);
        drain();
        check("err_sticky", 64'(bus.err), 64'd1);

        // Reset in WAIT_DONE: outputs clear, no done afterwards.
        exp_q.push_back('{OWN_CPU, 1'b1, 8'h00});
        bus.cpu_addr = 22'h0003FF;
        bus.cpu_req  = 1'b1;
        wait_ack(OWN_CPU, c);
        bus.cpu_req = 1'b0;
        c = 0;
        while (!bus.mc_busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("pre_reset_addr", 64'(bus.mc_addr), 64'h3FF);
        done0 = n_done;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("reset_mid_op_outputs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_reset", 64'(n_done - done0), 64'd0);
        cpu_op(1'b0, 22'h000123, 8'h00, 8'h5A);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
